// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the single RRIOT I/O register port between the 6502 CPU bus side
//   (requester 0) and the debug/host side (requester 1). Each granted access
//   is sequenced IDLE -> ISSUE -> WAIT -> DONE: one io_enable strobe, one
//   cycle for the io block's registered read data, then a one-cycle ack to
//   the winner carrying the captured read data.
//
// Parameters
//   ARB_MODE       0 = fixed priority (CPU wins) with host anti-starvation,
//                  1 = round-robin
//   HOST_MAX_WAIT  fixed mode: CPU grants a pending host may lose in a row
//                  before the host is forced through (1..15)
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   cpu_req/we_n/addr/wdata            CPU request (level, held until ack)
//   cpu_ack/rdata/err                  CPU completion pulse, read data, read error
//   host_*                             same set for the host requester
//   io_enable/we_n/a/di                access strobe and fields to the io block
//   io_do, io_oe                       registered read data and valid from io block

module io_bus_arbiter #(
    parameter int unsigned ARB_MODE      = 32'd0,
    parameter int unsigned HOST_MAX_WAIT = 32'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we_n,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic       cpu_err,
    input  logic       host_req,
    input  logic       host_we_n,
    input  logic [2:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       host_err,
    output logic       io_enable,
    output logic       io_we_n,
    output logic [2:0] io_a,
    output logic [7:0] io_di,
    input  logic [7:0] io_do,
    input  logic       io_oe
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(HOST_MAX_WAIT);

    state_t     state_r;
    state_t     state_next_s;
    logic       any_req_s;
    logic       grant_host_s;
    logic       win_host_r;       // 1 = access in flight belongs to host
    logic       rr_last_host_r;   // 1 = host was granted last
    logic [3:0] starve_cnt_r;     // CPU grants lost in a row by a pending host

    // Arbitration: pick the winner among the requests seen in IDLE.
    always_comb begin
        any_req_s    = cpu_req | host_req;
        grant_host_s = 1'b0;
        if (cpu_req && host_req) begin
            if (ARB_MODE == 32'd1) begin
                // Favour whoever was not granted last.
                grant_host_s = ~rr_last_host_r;
            end else begin
                grant_host_s = (starve_cnt_r >= MAX_WAIT_C);
            end
        end else if (host_req) begin
            grant_host_s = 1'b1;
        end else begin
            grant_host_s = 1'b0;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT:  state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant bookkeeping and io-side access fields, latched at grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_enable      <= 1'b0;
            io_we_n        <= 1'b1;
            io_a           <= 3'd0;
            io_di          <= 8'd0;
            win_host_r     <= 1'b0;
            rr_last_host_r <= 1'b1;
            starve_cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        io_enable      <= 1'b1;
                        win_host_r     <= grant_host_s;
                        rr_last_host_r <= grant_host_s;
                        io_we_n        <= grant_host_s ? host_we_n  : cpu_we_n;
                        io_a           <= grant_host_s ? host_addr  : cpu_addr;
                        io_di          <= grant_host_s ? host_wdata : cpu_wdata;
                    end
                    // A pending host that loses to the CPU ages; any host
                    // grant or an idle host starts the count over.
                    if (!host_req || grant_host_s) begin
                        starve_cnt_r <= 4'd0;
                    end else if (starve_cnt_r < MAX_WAIT_C) begin
                        starve_cnt_r <= starve_cnt_r + 4'd1;
                    end
                end
                ST_ISSUE: io_enable <= 1'b0;
                default:  io_enable <= 1'b0;
            endcase
        end
    end

    // Completion: capture read data in WAIT so it is valid alongside the ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= 8'd0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= 8'd0;
        end else begin
            cpu_ack  <= 1'b0;
            cpu_err  <= 1'b0;
            host_ack <= 1'b0;
            host_err <= 1'b0;
            if (state_r == ST_WAIT) begin
                if (win_host_r) begin
                    host_ack <= 1'b1;
                    if (io_we_n) begin
                        if (io_oe) begin
                            host_rdata <= io_do;
                        end else begin
                            host_err <= 1'b1;
                        end
                    end
                end else begin
                    cpu_ack <= 1'b1;
                    if (io_we_n) begin
                        if (io_oe) begin
                            cpu_rdata <= io_do;
                        end else begin
                            cpu_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter. Two instances share all inputs:
// u_dut0 in fixed-priority mode (HOST_MAX_WAIT = 2), u_dut1 in round-robin.
module tb_io_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we_n, host_req, host_we_n, io_oe;
    logic [2:0] cpu_addr, host_addr;
    logic [7:0] cpu_wdata, host_wdata, io_do;

    logic       cpu_ack0, cpu_err0, host_ack0, host_err0, io_enable0, io_we_n0;
    logic [7:0] cpu_rdata0, host_rdata0, io_di0;
    logic [2:0] io_a0;
    logic       cpu_ack1, cpu_err1, host_ack1, host_err1, io_enable1, io_we_n1;
    logic [7:0] cpu_rdata1, host_rdata1, io_di1;
    logic [2:0] io_a1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.ARB_MODE(32'd0), .HOST_MAX_WAIT(32'd2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0), .cpu_err(cpu_err0),
        .host_req(host_req), .host_we_n(host_we_n), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack0), .host_rdata(host_rdata0), .host_err(host_err0),
        .io_enable(io_enable0), .io_we_n(io_we_n0), .io_a(io_a0), .io_di(io_di0),
        .io_do(io_do), .io_oe(io_oe)
    );

    io_bus_arbiter #(.ARB_MODE(32'd1), .HOST_MAX_WAIT(32'd3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we_n(cpu_we_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1), .cpu_err(cpu_err1),
        .host_req(host_req), .host_we_n(host_we_n), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack1), .host_rdata(host_rdata1), .host_err(host_err1),
        .io_enable(io_enable1), .io_we_n(io_we_n1), .io_a(io_a1), .io_di(io_di1),
        .io_do(io_do), .io_oe(io_oe)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check reset values, then release.
    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we_n = 1'b1; cpu_addr = 3'd0; cpu_wdata = 8'd0;
        host_req = 1'b0; host_we_n = 1'b1; host_addr = 3'd0; host_wdata = 8'd0;
        io_do = 8'd0; io_oe = 1'b0;
        tick(); tick();
        n_tests++; if ({io_enable0, io_we_n0, io_a0, io_di0} !== {1'b0, 1'b1, 3'd0, 8'd0}) begin n_fail++; $display("FAIL reset_io: got en=%0b we_n=%0b a=%0d di=%h expected 0 1 0 00", io_enable0, io_we_n0, io_a0, io_di0); end
        n_tests++; if ({cpu_ack0, cpu_err0, host_ack0, host_err0} !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0000", {cpu_ack0, cpu_err0, host_ack0, host_err0}); end
        n_tests++; if ({cpu_rdata0, host_rdata0} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", {cpu_rdata0, host_rdata0}); end
        n_tests++; if ({io_enable1, io_we_n1, cpu_ack1, host_ack1} !== 4'b0100) begin n_fail++; $display("FAIL reset_rr_dut: got %b expected 0100", {io_enable1, io_we_n1, cpu_ack1, host_ack1}); end
        rst_n = 1'b1;
    endtask

    // CPU read of addr 0 returning 5A: strobe at k+1, ack at k+3.
    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 3'd0; io_do = 8'h5A; io_oe = 1'b1;
        n_tests++; if (io_enable0 !== 1'b0) begin n_fail++; $display("FAIL rd_no_early_strobe: got %0b expected 0", io_enable0); end
        tick();
        n_tests++; if ({io_enable0, io_a0, io_we_n0} !== {1'b1, 3'd0, 1'b1}) begin n_fail++; $display("FAIL rd_strobe: got en=%0b a=%0d we_n=%0b expected 1 0 1", io_enable0, io_a0, io_we_n0); end
        tick();
        n_tests++; if ({io_enable0, cpu_ack0} !== 2'b00) begin n_fail++; $display("FAIL rd_wait: got en/ack=%b expected 00", {io_enable0, cpu_ack0}); end
        tick();
        n_tests++; if ({cpu_ack0, cpu_err0, cpu_rdata0} !== {1'b1, 1'b0, 8'h5A}) begin n_fail++; $display("FAIL rd_ack: got ack=%0b err=%0b rdata=%h expected 1 0 5a", cpu_ack0, cpu_err0, cpu_rdata0); end
        cpu_req = 1'b0;
        tick();
        n_tests++; if ({cpu_ack0, io_enable0, cpu_rdata0} !== {1'b0, 1'b0, 8'h5A}) begin n_fail++; $display("FAIL rd_after: got ack=%0b en=%0b rdata=%h expected 0 0 5a", cpu_ack0, io_enable0, cpu_rdata0); end
    endtask

    // CPU read of addr 5 with io_oe low: ack and err pulse, rdata kept.
    task automatic test_read_err();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 3'd5; io_do = 8'h33; io_oe = 1'b0;
        tick();
        n_tests++; if ({io_enable0, io_a0} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL err_strobe: got en=%0b a=%0d expected 1 5", io_enable0, io_a0); end
        tick(); tick();
        n_tests++; if ({cpu_ack0, cpu_err0, cpu_rdata0} !== {1'b1, 1'b1, 8'h5A}) begin n_fail++; $display("FAIL err_ack: got ack=%0b err=%0b rdata=%h expected 1 1 5a", cpu_ack0, cpu_err0, cpu_rdata0); end
        cpu_req = 1'b0;
        tick();
        n_tests++; if ({cpu_ack0, cpu_err0} !== 2'b00) begin n_fail++; $display("FAIL err_pulse_len: got %b expected 00", {cpu_ack0, cpu_err0}); end
    endtask

    // Host write addr 1 of F0 with io_oe low: no err, host_rdata untouched.
    task automatic test_host_write();
        host_req = 1'b1; host_we_n = 1'b0; host_addr = 3'd1; host_wdata = 8'hF0; io_oe = 1'b0; io_do = 8'hEE;
        tick();
        n_tests++; if ({io_enable0, io_we_n0, io_a0, io_di0} !== {1'b1, 1'b0, 3'd1, 8'hF0}) begin n_fail++; $display("FAIL wr_strobe: got en=%0b we_n=%0b a=%0d di=%h expected 1 0 1 f0", io_enable0, io_we_n0, io_a0, io_di0); end
        host_wdata = 8'h0F;
        tick();
        n_tests++; if ({io_enable0, io_di0} !== {1'b0, 8'hF0}) begin n_fail++; $display("FAIL wr_latched: got en=%0b di=%h expected 0 f0", io_enable0, io_di0); end
        tick();
        n_tests++; if ({host_ack0, host_err0, host_rdata0, cpu_ack0, cpu_rdata0} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h5A}) begin n_fail++; $display("FAIL wr_ack: got ack=%0b err=%0b hrd=%h cack=%0b crd=%h expected 1 0 00 0 5a", host_ack0, host_err0, host_rdata0, cpu_ack0, cpu_rdata0); end
        host_req = 1'b0;
        tick();
        n_tests++; if (host_ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_len: got %0b expected 0", host_ack0); end
    endtask

    // Fixed priority, HOST_MAX_WAIT=2, both requesting: C C H C C H.
    task automatic test_fixed_starve();
        int order[$];
        int exp_order[6] = '{0, 0, 1, 0, 0, 1};
        test_reset();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 3'd2;
        host_req = 1'b1; host_we_n = 1'b1; host_addr = 3'd6;
        io_do = 8'h11; io_oe = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (cpu_ack0)  order.push_back(0);
            if (host_ack0) order.push_back(1);
        end
        cpu_req = 1'b0; host_req = 1'b0;
        n_tests++; if (order.size() !== 6) begin n_fail++; $display("FAIL fixed_count: got %0d acks expected 6", order.size()); end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (i >= order.size()) begin n_fail++; $display("FAIL fixed_order[%0d]: got none expected %0d", i, exp_order[i]); end
            else if (order[i] !== exp_order[i]) begin n_fail++; $display("FAIL fixed_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
        end
        tick(); tick(); tick(); tick();
    endtask

    // Round-robin, both requesting from reset: C H C H, acks 4 cycles apart.
    task automatic test_round_robin();
        int who[$];
        int when[$];
        test_reset();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 3'd3;
        host_req = 1'b1; host_we_n = 1'b1; host_addr = 3'd4;
        io_do = 8'h22; io_oe = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (cpu_ack1)  begin who.push_back(0); when.push_back(c); end
            if (host_ack1) begin who.push_back(1); when.push_back(c); end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        n_tests++; if (who.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d acks expected 4", who.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= who.size()) begin n_fail++; $display("FAIL rr_order[%0d]: got none expected %0d", i, i % 2); end
            else if (who[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, who[i], i % 2); end
        end
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (i >= when.size()) begin n_fail++; $display("FAIL rr_spacing[%0d]: got none expected 4", i); end
            else if (when[i] - when[i-1] !== 4) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", i, when[i] - when[i-1]); end
        end
        n_tests++; if (host_rdata1 !== 8'h22) begin n_fail++; $display("FAIL rr_host_rdata: got %h expected 22", host_rdata1); end
        tick(); tick(); tick(); tick();
    endtask

    // Reset during WAIT abandons the access; held req is re-served from scratch.
    task automatic test_reset_in_wait();
        test_reset();
        cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 3'd3; io_do = 8'h77; io_oe = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++; if ({cpu_ack0, io_enable0, cpu_rdata0} !== {1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL rst_wait_abort: got ack=%0b en=%0b rdata=%h expected 0 0 00", cpu_ack0, io_enable0, cpu_rdata0); end
        rst_n = 1'b1;
        tick();
        n_tests++; if ({io_enable0, cpu_ack0} !== 2'b10) begin n_fail++; $display("FAIL rst_wait_restrobe: got en/ack=%b expected 10", {io_enable0, cpu_ack0}); end
        tick();
        n_tests++; if (cpu_ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_wait_early_ack: got %0b expected 0", cpu_ack0); end
        tick();
        n_tests++; if ({cpu_ack0, cpu_rdata0} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL rst_wait_ack: got ack=%0b rdata=%h expected 1 77", cpu_ack0, cpu_rdata0); end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_read_err();
        test_host_write();
        test_fixed_starve();
        test_round_robin();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
